imm_encoder: RTL and testbench
==============================

# imm_encoder

Streaming RISC-V instruction encoder for the OTTER toolchain path. It takes an instruction template, a format code and a 32-bit immediate, and scatters the immediate into the correct bit positions for U/I/S/B/J formats. This is the exact inverse of the core's immediate generator. It also expands the `LI` pseudo-op into `LUI`/`ADDI` pairs. It sits between the boot-loader/program-builder logic and instruction memory write port, behind valid/ready handshakes on both sides.

## Interface
- Parameters: none.
- `CLK` in 1: single clock; all state updates on rising edge.
- `RST` in 1: **synchronous, active-high** reset.
- `IN_VALID` in 1: request valid.
- `IN_READY` out 1: request accepted when `IN_VALID && IN_READY` at the edge.
- `IN_FMT` in 3: 0=U, 1=I, 2=S, 3=B, 4=J, 5=LI, 6–7 reserved.
- `IN_BASE` in 32: template (opcode, funct, rd, rs1, rs2). Immediate bit positions are ignored and overwritten. For LI only `IN_BASE[11:7]` (rd) is used.
- `IN_IMM` in 32: immediate, two's complement (U: full value, low 12 bits expected 0).
- `OUT_VALID` out 1: output word valid.
- `OUT_READY` in 1: word consumed when `OUT_VALID && OUT_READY`.
- `OUT_INSTR` out 32: encoded instruction.
- `OUT_LAST` out 1: final word of the current request.
- `OUT_ERR` out 1: range/alignment error on this word.

## Operation
- Encoding (`i` = `IN_IMM`, non-immediate bits taken from `IN_BASE`):
  - U: `[31:12]=i[31:12]`.
  - I: `[31:20]=i[11:0]`.
  - S: `[31:25]=i[11:5]`, `[11:7]=i[4:0]`.
  - B: `[31]=i[12]`, `[7]=i[11]`, `[30:25]=i[10:5]`, `[11:8]=i[4:1]`.
  - J: `[31]=i[20]`, `[19:12]=i[19:12]`, `[20]=i[11]`, `[30:21]=i[10:1]`.
- LI, with rd = `IN_BASE[11:7]`:
  - If −2048 ≤ i ≤ 2047: emit one word `ADDI rd,x0,i` = `{i[11:0],5'd0,3'b000,rd,7'h13}`.
  - Otherwise compute `hi=(i+32'h800)[31:12]` (32-bit wrap) and `lo=i−{hi,12'h0}` (fits signed 12 bits).
  - Emit `LUI rd,hi` = `{hi,rd,7'h37}`.
  - If `lo≠0`, then emit `ADDI rd,rd,lo` = `{lo[11:0],rd,3'b000,rd,7'h13}`.
  - LI never sets `OUT_ERR`.
- Reserved `IN_FMT`: emit `IN_BASE` unchanged with `OUT_ERR=1`, `OUT_LAST=1`.
- State machine:
  - `EMPTY`: no word held. Accepting a request goes to `ONE`, or to `PAIR` for a two-word LI.
  - `ONE`: one word presented. On output handshake, go to `EMPTY`, or stay in `ONE` if a new request is accepted in the same cycle.
  - `PAIR`: LUI presented, ADDI held internally. On output handshake, present the ADDI and go to `ONE`.
- `IN_READY = !RST && (state==EMPTY || (state==ONE && OUT_READY))`. `IN_READY` is 0 in `PAIR`.

## Timing
- Reset values: `OUT_VALID=0`, `OUT_INSTR=0`, `OUT_LAST=0`, `OUT_ERR=0`, state `EMPTY`. `IN_READY=0` while `RST=1` and 1 the cycle after.
- Latency: request accepted at edge N gives `OUT_VALID=1` with the word after edge N (registered output, no combinational in→out path).
- Throughput: 1 word/cycle when `OUT_READY=1`. Consume and accept in the same cycle is supported in `ONE`.
- Backpressure: while `OUT_VALID && !OUT_READY`, `OUT_INSTR`/`OUT_LAST`/`OUT_ERR` are held stable. Inputs are sampled only at accept.
- Two-word LI occupies 2 output cycles minimum. `OUT_LAST=0` on LUI and 1 on ADDI.
- `RST` mid-operation (including in `PAIR`) discards all held words. `OUT_VALID=0` after that edge, and the pending ADDI is never emitted.

## Configuration
- `IMM_ENC_RANGE_CHECK_EN` defined: `OUT_ERR=1` under any of these conditions. The word is still emitted with truncated bits.
  - I/S with i outside [−2048, 2047].
  - B with i outside [−4096, 4094] or `i[0]=1`.
  - J with i outside [−2^20, 2^20−2] or `i[0]=1`.
  - U with `i[11:0]≠0`.
- Undefined: no checking. `OUT_ERR` is set only for reserved formats. Encoding is pure truncation as above.

## Test plan
- I: `IN_BASE=0x00000293`, i=−1 → `0xFFF00293`, LAST=1, ERR=0, `OUT_VALID` one cycle after accept.
- B: `IN_BASE=0x00000063`, i=−4 → `0xFE000EE3`. J: `IN_BASE=0x0000006F`, i=−4 → `0xFFDFF06F`.
- LI rd=10, i=`0x12345FFF`, `OUT_READY` low 3 cycles then high → `0x12346537` (LAST=0) held stable for those 3 cycles, then `0xFFF50513` (LAST=1). `IN_READY=0` throughout `PAIR`.
- LI rd=10, i=`0x00400000` → single `0x00400537`, LAST=1. LI i=5 → `0x00500513`.
- I with i=2048 and `IN_BASE=0x13` → `0x80000013`. ERR=1 with the macro, ERR=0 without. B with i=3 → ERR=1 only with the macro.
- Four I requests on consecutive cycles with `OUT_READY=1` → four words on consecutive cycles. Separately, `RST` asserted the cycle after the LUI is consumed → no ADDI, `OUT_VALID=0`.

Source files
------------

// File: rtl/imm_encoder_if.sv
// imm_encoder_if: request and output-word handshake bundle for imm_encoder.
// The master side is the program builder / boot loader. The slave side is the encoder.
interface imm_encoder_if;
  logic        IN_VALID;
  logic        IN_READY;
  logic [2:0]  IN_FMT;
  logic [31:0] IN_BASE;
  logic [31:0] IN_IMM;
  logic        OUT_VALID;
  logic        OUT_READY;
  logic [31:0] OUT_INSTR;
  logic        OUT_LAST;
  logic        OUT_ERR;

  modport master (
    output IN_VALID, IN_FMT, IN_BASE, IN_IMM, OUT_READY,
    input  IN_READY, OUT_VALID, OUT_INSTR, OUT_LAST, OUT_ERR
  );

  modport slave (
    input  IN_VALID, IN_FMT, IN_BASE, IN_IMM, OUT_READY,
    output IN_READY, OUT_VALID, OUT_INSTR, OUT_LAST, OUT_ERR
  );
endinterface

// File: rtl/imm_encoder.sv
// imm_encoder: scatters a 32-bit immediate into a RISC-V instruction template
// for the U/I/S/B/J formats, and expands the LI pseudo-op into ADDI or LUI(+ADDI).
// The encoder holds at most one presented word plus one pending ADDI.
// Optional feature: define IMM_ENC_RANGE_CHECK_EN to flag immediates that are
// out of range or misaligned for their format (OUT_ERR). The word is still emitted truncated.
module imm_encoder (
  input  logic         CLK,
  input  logic         RST,
  imm_encoder_if.slave bus
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_PAIR  = 2'd2
  } state_e;

  // True when v fits a signed 12-bit field (bits 31..11 all equal).
  function automatic logic fits_s12(input logic [31:0] v);
    return (&v[31:11]) | ~(|v[31:11]);
  endfunction

`ifdef IMM_ENC_RANGE_CHECK_EN
  // True when v fits a signed 13-bit field (B-type offset range before alignment).
  function automatic logic fits_s13(input logic [31:0] v);
    return (&v[31:12]) | ~(|v[31:12]);
  endfunction

  // True when v fits a signed 21-bit field (J-type offset range before alignment).
  function automatic logic fits_s21(input logic [31:0] v);
    return (&v[31:20]) | ~(|v[31:20]);
  endfunction
`endif

  state_e      state_q;
  logic        out_valid_q;
  logic [31:0] out_instr_q;
  logic        out_last_q;
  logic        out_err_q;
  logic [31:0] pend_q;

  logic        in_ready_s;
  logic        accept_s;
  logic        out_fire_s;
  logic [4:0]  rd_s;
  logic [19:0] li_hi_s;
  logic [31:0] word_d;
  logic [31:0] addi_d;
  logic        two_d;
  logic        err_d;

  assign in_ready_s = !RST && ((state_q == ST_EMPTY) ||
                               ((state_q == ST_ONE) && bus.OUT_READY));
  assign accept_s   = bus.IN_VALID && in_ready_s;
  assign out_fire_s = out_valid_q && bus.OUT_READY;

  assign bus.IN_READY  = in_ready_s;
  assign bus.OUT_VALID = out_valid_q;
  assign bus.OUT_INSTR = out_instr_q;
  assign bus.OUT_LAST  = out_last_q;
  assign bus.OUT_ERR   = out_err_q;

  // Encode the request on the input side into the first word, an optional pending ADDI, and an error flag.
  always_comb begin
    rd_s    = bus.IN_BASE[11:7];
    // (i + 0x800)[31:12] is i[31:12] plus the carry out of bit 11, which is i[11].
    li_hi_s = bus.IN_IMM[31:12] + {19'd0, bus.IN_IMM[11]};
    word_d  = bus.IN_BASE;
    addi_d  = 32'h0000_0000;
    two_d   = 1'b0;
    err_d   = 1'b0;
    case (bus.IN_FMT)
      3'd0: begin
        word_d = {bus.IN_IMM[31:12], bus.IN_BASE[11:0]};
`ifdef IMM_ENC_RANGE_CHECK_EN
        err_d  = (bus.IN_IMM[11:0] != 12'd0);
`endif
      end
      3'd1: begin
        word_d = {bus.IN_IMM[11:0], bus.IN_BASE[19:0]};
`ifdef IMM_ENC_RANGE_CHECK_EN
        err_d  = !fits_s12(bus.IN_IMM);
`endif
      end
      3'd2: begin
        word_d = {bus.IN_IMM[11:5], bus.IN_BASE[24:12], bus.IN_IMM[4:0], bus.IN_BASE[6:0]};
`ifdef IMM_ENC_RANGE_CHECK_EN
        err_d  = !fits_s12(bus.IN_IMM);
`endif
      end
      3'd3: begin
        word_d = {bus.IN_IMM[12], bus.IN_IMM[10:5], bus.IN_BASE[24:12],
                  bus.IN_IMM[4:1], bus.IN_IMM[11], bus.IN_BASE[6:0]};
`ifdef IMM_ENC_RANGE_CHECK_EN
        err_d  = !fits_s13(bus.IN_IMM) || bus.IN_IMM[0];
`endif
      end
      3'd4: begin
        word_d = {bus.IN_IMM[20], bus.IN_IMM[10:1], bus.IN_IMM[11],
                  bus.IN_IMM[19:12], bus.IN_BASE[11:0]};
`ifdef IMM_ENC_RANGE_CHECK_EN
        err_d  = !fits_s21(bus.IN_IMM) || bus.IN_IMM[0];
`endif
      end
      3'd5: begin
        if (fits_s12(bus.IN_IMM)) begin
          word_d = {bus.IN_IMM[11:0], 5'd0, 3'b000, rd_s, 7'h13};
        end else begin
          // lo = i - {hi,12'h0} has the same low 12 bits as i.
          word_d = {li_hi_s, rd_s, 7'h37};
          addi_d = {bus.IN_IMM[11:0], rd_s, 3'b000, rd_s, 7'h13};
          two_d  = (bus.IN_IMM[11:0] != 12'd0);
        end
      end
      default: begin
        word_d = bus.IN_BASE;
        err_d  = 1'b1;
      end
    endcase
  end

  // Output FSM: present a word, hold it under backpressure, and release the pending ADDI after the LUI.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= ST_EMPTY;
      out_valid_q <= 1'b0;
      out_instr_q <= 32'h0000_0000;
      out_last_q  <= 1'b0;
      out_err_q   <= 1'b0;
      pend_q      <= 32'h0000_0000;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept_s) begin
            state_q     <= two_d ? ST_PAIR : ST_ONE;
            out_valid_q <= 1'b1;
            out_instr_q <= word_d;
            out_last_q  <= !two_d;
            out_err_q   <= err_d;
            pend_q      <= addi_d;
          end
        end
        ST_ONE: begin
          if (out_fire_s) begin
            if (accept_s) begin
              state_q     <= two_d ? ST_PAIR : ST_ONE;
              out_valid_q <= 1'b1;
              out_instr_q <= word_d;
              out_last_q  <= !two_d;
              out_err_q   <= err_d;
              pend_q      <= addi_d;
            end else begin
              state_q     <= ST_EMPTY;
              out_valid_q <= 1'b0;
            end
          end
        end
        ST_PAIR: begin
          if (out_fire_s) begin
            state_q     <= ST_ONE;
            out_valid_q <= 1'b1;
            out_instr_q <= pend_q;
            out_last_q  <= 1'b1;
            out_err_q   <= 1'b0;
          end
        end
        default: begin
          state_q     <= ST_EMPTY;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imm_encoder.sv
// tb_imm_encoder: directed self-checking bench for imm_encoder.
// Expected words are hand-computed. The ERR expectations follow IMM_ENC_RANGE_CHECK_EN.
module tb_imm_encoder;

  logic CLK;
  logic RST;
  int   pass_cnt;
  int   total_cnt;

  imm_encoder_if bus ();

  imm_encoder dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt = total_cnt + 1;
    assert (obs === exp) begin
      pass_cnt = pass_cnt + 1;
    end else begin
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic expect_word(input string tag, input logic [31:0] instr,
                             input logic last, input logic err);
    check({tag, "_valid"}, {31'd0, bus.OUT_VALID}, 32'd1);
    check({tag, "_instr"}, bus.OUT_INSTR, instr);
    check({tag, "_last"},  {31'd0, bus.OUT_LAST}, {31'd0, last});
    check({tag, "_err"},   {31'd0, bus.OUT_ERR},  {31'd0, err});
  endtask

  // Drive one request at a negedge and return at the next negedge (accepted at the edge in between).
  task automatic req(input logic [2:0] fmt, input logic [31:0] base, input logic [31:0] imm);
    bus.IN_VALID = 1'b1;
    bus.IN_FMT   = fmt;
    bus.IN_BASE  = base;
    bus.IN_IMM   = imm;
    @(negedge CLK);
    bus.IN_VALID = 1'b0;
  endtask

  logic rc_err;
  logic [31:0] exp_w;

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
`ifdef IMM_ENC_RANGE_CHECK_EN
    rc_err = 1'b1;
`else
    rc_err = 1'b0;
`endif
    RST           = 1'b1;
    bus.IN_VALID  = 1'b0;
    bus.IN_FMT    = 3'd0;
    bus.IN_BASE   = 32'h0;
    bus.IN_IMM    = 32'h0;
    bus.OUT_READY = 1'b1;

    // Reset state
    @(negedge CLK);
    @(negedge CLK);
    check("rst_valid", {31'd0, bus.OUT_VALID}, 32'd0);
    check("rst_instr", bus.OUT_INSTR, 32'h0);
    check("rst_last",  {31'd0, bus.OUT_LAST}, 32'd0);
    check("rst_err",   {31'd0, bus.OUT_ERR}, 32'd0);
    check("rst_ready", {31'd0, bus.IN_READY}, 32'd0);
    RST = 1'b0;
    @(negedge CLK);
    check("post_rst_ready", {31'd0, bus.IN_READY}, 32'd1);

    // I-type, latency one cycle after accept
    bus.IN_VALID = 1'b1;
    bus.IN_FMT   = 3'd1;
    bus.IN_BASE  = 32'h0000_0293;
    bus.IN_IMM   = 32'hFFFF_FFFF;
    check("i_pre_valid", {31'd0, bus.OUT_VALID}, 32'd0);
    @(negedge CLK);
    bus.IN_VALID = 1'b0;
    expect_word("i_neg1", 32'hFFF0_0293, 1'b1, 1'b0);
    @(negedge CLK);
    check("i_drain", {31'd0, bus.OUT_VALID}, 32'd0);

    // B and J with -4
    req(3'd3, 32'h0000_0063, 32'hFFFF_FFFC);
    expect_word("b_neg4", 32'hFE00_0EE3, 1'b1, 1'b0);
    @(negedge CLK);
    req(3'd4, 32'h0000_006F, 32'hFFFF_FFFC);
    expect_word("j_neg4", 32'hFFDF_F06F, 1'b1, 1'b0);
    @(negedge CLK);

    // U and S
    req(3'd0, 32'h0000_02B7, 32'hABCD_E000);
    expect_word("u", 32'hABCD_E2B7, 1'b1, 1'b0);
    @(negedge CLK);
    req(3'd2, 32'h0000_0023, 32'hFFFF_FFF8);
    expect_word("s_neg8", 32'hFE00_0C23, 1'b1, 1'b0);
    @(negedge CLK);

    // LI two-word with backpressure
    bus.OUT_READY = 1'b0;
    req(3'd5, 32'h0000_0500, 32'h1234_5FFF);
    for (int k = 0; k < 3; k++) begin
      expect_word("li_lui_hold", 32'h1234_6537, 1'b0, 1'b0);
      check("li_pair_ready", {31'd0, bus.IN_READY}, 32'd0);
      @(negedge CLK);
    end
    bus.OUT_READY = 1'b1;
    check("li_pair_ready_or", {31'd0, bus.IN_READY}, 32'd0);
    @(negedge CLK);
    expect_word("li_addi", 32'hFFF5_0513, 1'b1, 1'b0);
    @(negedge CLK);
    check("li_drain", {31'd0, bus.OUT_VALID}, 32'd0);

    // LI single LUI (lo == 0) and single ADDI
    req(3'd5, 32'h0000_0500, 32'h0040_0000);
    expect_word("li_lui_only", 32'h0040_0537, 1'b1, 1'b0);
    @(negedge CLK);
    check("li_lui_only_drain", {31'd0, bus.OUT_VALID}, 32'd0);
    req(3'd5, 32'h0000_0500, 32'h0000_0005);
    expect_word("li_small", 32'h0050_0513, 1'b1, 1'b0);
    @(negedge CLK);

    // Range-check boundaries
    req(3'd1, 32'h0000_0013, 32'h0000_0800);
    expect_word("i_2048", 32'h8000_0013, 1'b1, rc_err);
    @(negedge CLK);
    req(3'd1, 32'h0000_0013, 32'h0000_07FF);
    expect_word("i_2047", 32'h7FF0_0013, 1'b1, 1'b0);
    @(negedge CLK);
    req(3'd3, 32'h0000_0063, 32'h0000_0003);
    expect_word("b_odd", 32'h0000_0163, 1'b1, rc_err);
    @(negedge CLK);

    // Reserved format passes the template through with ERR
    req(3'd6, 32'hDEAD_BEEF, 32'h1234_5678);
    expect_word("reserved", 32'hDEAD_BEEF, 1'b1, 1'b1);
    @(negedge CLK);

    // Four back-to-back I requests
    bus.IN_VALID = 1'b1;
    bus.IN_FMT   = 3'd1;
    bus.IN_BASE  = 32'h0000_0013;
    for (int k = 0; k < 4; k++) begin
      bus.IN_IMM = 32'(k + 1);
      @(negedge CLK);
      exp_w = 32'h0000_0013 | (32'(k + 1) << 20);
      expect_word("stream", exp_w, 1'b1, 1'b0);
      check("stream_ready", {31'd0, bus.IN_READY}, 32'd1);
    end
    bus.IN_VALID = 1'b0;
    @(negedge CLK);
    check("stream_drain", {31'd0, bus.OUT_VALID}, 32'd0);

    // Reset while the pending ADDI is held
    req(3'd5, 32'h0000_0500, 32'h1234_5FFF);
    expect_word("rst_pair_lui", 32'h1234_6537, 1'b0, 1'b0);
    RST = 1'b1;
    @(negedge CLK);
    check("rst_pair_valid", {31'd0, bus.OUT_VALID}, 32'd0);
    check("rst_pair_ready", {31'd0, bus.IN_READY}, 32'd0);
    RST = 1'b0;
    @(negedge CLK);
    check("rst_pair_no_addi1", {31'd0, bus.OUT_VALID}, 32'd0);
    check("rst_pair_ready_back", {31'd0, bus.IN_READY}, 32'd1);
    @(negedge CLK);
    check("rst_pair_no_addi2", {31'd0, bus.OUT_VALID}, 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
